// File: rtl/div16by8_seq_if.sv
// rtl/div16by8_seq_if.sv - request/result bundle for the 16/8 sequential divider
interface div16by8_seq_if;
  logic        start;
  logic        is_signed;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_err;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_err
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_err
  );
endinterface

// File: rtl/div16by8_seq.sv
// rtl/div16by8_seq.sv - 16/8 restoring divider (DIV/IDIV), one quotient bit per clock
// Optional macro DIV_OVF_CHECK_EN: quotient overflow raises div_err and zeroes the results.
module div16by8_seq (
  input  logic          clk,
  input  logic          rst_n,
  div16by8_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, RUN, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [7:0]  prem_q, prem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [7:0]  quo_q, quo_d;
  logic [7:0]  rem_q, rem_d;
  logic        err_q, err_d;

  logic [8:0]  shifted;
  logic [7:0]  sub;
  logic        ge;
  logic [7:0]  q_fix;
  logic [7:0]  r_fix;
`ifdef DIV_OVF_CHECK_EN
  logic        ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // 9-bit partial remainder: the shifted-in bit can push it past 255 before the subtract
  always_comb begin
    shifted = {prem_q, work_q[15]};
    ge      = (shifted >= {1'b0, dvs_q});
    sub     = shifted[7:0] - dvs_q;
    q_fix   = qneg_q ? (8'd0 - work_q[7:0]) : work_q[7:0];
    r_fix   = rneg_q ? (8'd0 - prem_q) : prem_q;
`ifdef DIV_OVF_CHECK_EN
    if (sgn_q) ovf = qneg_q ? (work_q > 16'd128) : (work_q > 16'd127);
    else       ovf = (work_q > 16'd255);
`endif
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          work_d  = bus.dividend;
          dvs_d   = bus.divisor;
          sgn_d   = bus.is_signed;
          cnt_d   = 5'd0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (dvs_q == 8'd0) begin
          // divide-by-zero dwells one extra cycle so it reports two edges after start
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else begin
            err_d   = 1'b1;
            quo_d   = 8'd0;
            rem_d   = 8'd0;
            cnt_d   = 5'd0;
            state_d = DONE;
          end
        end else begin
          work_d  = (sgn_q && work_q[15]) ? (16'd0 - work_q) : work_q;
          dvs_d   = (sgn_q && dvs_q[7]) ? (8'd0 - dvs_q) : dvs_q;
          qneg_d  = sgn_q && (work_q[15] ^ dvs_q[7]);
          rneg_d  = sgn_q && work_q[15];
          prem_d  = 8'd0;
          cnt_d   = 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = {work_q[14:0], ge};
        prem_d = ge ? sub : shifted[7:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd15) state_d = FIX;
      end
      FIX: begin
`ifdef DIV_OVF_CHECK_EN
        if (ovf) begin
          err_d = 1'b1;
          quo_d = 8'd0;
          rem_d = 8'd0;
        end else begin
          err_d = 1'b0;
          quo_d = q_fix;
          rem_d = r_fix;
        end
`else
        err_d = 1'b0;
        quo_d = q_fix;
        rem_d = r_fix;
`endif
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_err   = err_q;
endmodule

// File: tb/tb_div16by8_seq.sv
// tb/tb_div16by8_seq.sv - vector table, random-vs-model and corner sequences for div16by8_seq
module tb_div16by8_seq;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  div16by8_seq_if bus ();

  div16by8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic (truncating division, remainder follows dividend)
  function automatic void model(input logic s, input logic [15:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output logic e);
    int na, nb, nq, nr;
    logic ovf;
    na = s ? int'({{16{a[15]}}, a}) : int'({16'd0, a});
    nb = s ? int'({{24{b[7]}}, b})  : int'({24'd0, b});
    if (nb == 0) begin
      e = 1'b1; q = 8'd0; r = 8'd0;
    end else begin
      nq  = na / nb;
      nr  = na % nb;
      ovf = s ? (nq < -128 || nq > 127) : (nq > 255);
`ifdef DIV_OVF_CHECK_EN
      if (ovf) begin
        e = 1'b1; q = 8'd0; r = 8'd0;
      end else begin
        e = 1'b0; q = nq[7:0]; r = nr[7:0];
      end
`else
      e = 1'b0; q = nq[7:0]; r = nr[7:0];
`endif
    end
  endfunction

  task automatic run_op(input logic s, input logic [15:0] dvd, input logic [7:0] dvs,
                        output logic [7:0] q, output logic [7:0] r, output logic e,
                        output int lat);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    q = bus.quotient;
    r = bus.remainder;
    e = bus.div_err;
    @(posedge clk);
    #1;
    chk("done_single_cycle", {bus.done, bus.busy}, 0);
  endtask

  initial begin
    logic [7:0]  q, r, eq, er;
    logic        e, ee;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic        s;
    int          lat, seen;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 18};
    vecs[1]  = '{1'b1, 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 18};
    vecs[2]  = '{1'b0, 16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 2};
    vecs[3]  = '{1'b1, 16'h8000, 8'h00, 8'h00, 8'h00, 1'b1, 2};
`ifdef DIV_OVF_CHECK_EN
    vecs[4]  = '{1'b0, 16'h1000, 8'h02, 8'h00, 8'h00, 1'b1, 18};
    vecs[6]  = '{1'b1, 16'h0080, 8'h01, 8'h00, 8'h00, 1'b1, 18};
    vecs[7]  = '{1'b0, 16'hFFFF, 8'hFF, 8'h00, 8'h00, 1'b1, 18};
`else
    vecs[4]  = '{1'b0, 16'h1000, 8'h02, 8'h00, 8'h00, 1'b0, 18};
    vecs[6]  = '{1'b1, 16'h0080, 8'h01, 8'h80, 8'h00, 1'b0, 18};
    vecs[7]  = '{1'b0, 16'hFFFF, 8'hFF, 8'h01, 8'h00, 1'b0, 18};
`endif
    vecs[5]  = '{1'b1, 16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 18};
    vecs[8]  = '{1'b0, 16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 18};
    vecs[9]  = '{1'b1, 16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 18};
    vecs[10] = '{1'b1, 16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 18};
    vecs[11] = '{1'b0, 16'h7FFF, 8'h80, 8'hFF, 8'h7F, 1'b0, 18};

    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quotient", bus.quotient, 0);
    chk("rst_remainder", bus.remainder, 0);
    chk("rst_div_err", bus.div_err, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].dvd, vecs[i].dvs, q, r, e, lat);
      chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d_div_err", i), e, vecs[i].e);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 60; i++) begin
      s   = 1'($urandom_range(0, 1));
      dvs = 8'($urandom);
      if ($urandom_range(0, 9) == 0) dvs = 8'd0;
      if ($urandom_range(0, 1) == 1) dvd = 16'($urandom_range(0, 32767) >> $urandom_range(0, 9));
      else                           dvd = 16'($urandom);
      if (s && $urandom_range(0, 3) == 0) dvd = 16'd0 - dvd;
      model(s, dvd, dvs, eq, er, ee);
      run_op(s, dvd, dvs, q, r, e, lat);
      chk($sformatf("rnd%0d_quotient", i), q, eq);
      chk($sformatf("rnd%0d_remainder", i), r, er);
      chk($sformatf("rnd%0d_div_err", i), e, ee);
      chk($sformatf("rnd%0d_latency", i), lat, (dvs == 8'd0) ? 2 : 18);
    end

    // start asserted mid-RUN with different operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 16'h0064; bus.divisor = 8'h07;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 16'h8000; bus.divisor = 8'h03;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int n = 7; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    chk("ignored_start_latency", lat, 18);
    chk("ignored_start_quotient", bus.quotient, 8'h0E);
    chk("ignored_start_remainder", bus.remainder, 8'h02);
    chk("ignored_start_div_err", bus.div_err, 0);
    @(posedge clk);

    // reset after edge 9 aborts the operation and clears all outputs at once
    run_op(1'b1, 16'hFF9C, 8'h07, q, r, e, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 16'h0064; bus.divisor = 8'h07;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_quotient", bus.quotient, 0);
    chk("abort_remainder", bus.remainder, 0);
    chk("abort_div_err", bus.div_err, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_no_done", seen, 0);

    run_op(1'b0, 16'h0064, 8'h07, q, r, e, lat);
    chk("post_reset_latency", lat, 18);
    chk("post_reset_quotient", q, 8'h0E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
